rr_arb_mux: RTL
===============

# rr_arb_mux

Parametrised N-to-1 datapath multiplexer with round-robin arbitration, valid/ready handshaking on every channel, and a registered output stage. It replaces fixed-select 4:1 multiplexing where several producers share one consumer, such as instruction/data-port sharing of a single memory bus. Selection is derived from request state rather than an external select. An optional per-channel lock holds the grant across multi-beat transfers.

## Interface
- WIDTH, 32: data width per channel, ≥1.
- N, 4: number of input channels, ≥2. Need not be a power of two.
- SELW (localparam): $clog2(N), the width of out_sel.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  per-channel request; bit i is channel i.
- in_data  in  N*WIDTH  channel i at [i*WIDTH +: WIDTH].
- in_lock  in  N  per-channel lock qualifier, sampled with the beat.
- in_ready  out  N  one-hot or zero grant/accept.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered beat data.
- out_sel  out  SELW  index of the channel that produced out_data.
- out_ready  in  1  consumer accepts the beat.

## Operation
- Single-entry output register (out_valid, out_data, out_sel).
- Register has space when out_valid=0 or out_ready=1.
- Round-robin pointer ptr (SELW bits, values 0..N-1).
- Grant g is the first i with in_valid[i]=1, searching ptr, ptr+1, …, wrapping modulo N (not modulo 2^SELW).
- in_ready[g] = space. All other bits are 0. in_ready = 0 when no channel is valid or rst=1.
- Transfer occurs when in_valid[g] & in_ready[g]. Register loads in_data[g], out_sel<=g, out_valid<=1.
- Output drain occurs when out_valid & out_ready. If there is no simultaneous transfer, out_valid<=0. Drain and load in the same cycle is legal and gives full throughput.
- Unlocked transfer (in_lock[g]=0): ptr <= (g+1) mod N.
- Locked transfer (in_lock[g]=1):
  - locked<=1, lock_ch<=g; ptr is unchanged.
  - While locked, the grant is restricted to lock_ch. Other channels see in_ready=0 even if lock_ch deasserts in_valid.
  - Lock releases on a transfer from lock_ch with in_lock=0. Then locked<=0 and ptr <= (lock_ch+1) mod N.
- Producers must hold in_valid and in_data stable until accepted. A drop before acceptance is a protocol violation and its behaviour is unspecified.
- Each accepted beat appears exactly once on the output, in acceptance order. There is no loss and no duplication.
- Reset, including mid-transfer: the held beat is discarded. out_valid=0, out_data=0, out_sel=0, ptr=0, locked=0, lock_ch=0.

## Timing
- Latency: transfer in cycle t gives out_valid=1 with that beat in cycle t+1.
- Throughput: 1 beat/cycle with out_ready held at 1.
- out_valid, out_data and out_sel are pure register outputs. There is no combinational path from in_* to out_*.
- in_ready depends combinationally on in_valid, out_ready and state. It does not depend on in_data or in_lock.
- With out_valid=1 and out_ready=0, in_ready=0 and out_data/out_sel hold stable.
- rst assertion clears all state immediately, without waiting for clk. The first edge after deassertion may accept a beat.

## Test plan
- N=4, WIDTH=32, only in_valid=4'b0100 with ch2 data 0xDEADBEEF, out_ready=1:
  - in_ready=4'b0100 at the edge.
  - Next cycle: out_valid=1, out_data=0xDEADBEEF, out_sel=2.
- All four channels continuously valid, lock=0, out_ready=1, from reset:
  - out_sel sequence is 0,1,2,3,0,1.
  - One beat per cycle, with no bubble after the first.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1:
  - in_ready=0, and out_data is unchanged.
  - After release, the beat drains and the next grant proceeds; the scoreboard shows no loss or duplication.
- Lock: ch0, ch1 and ch2 all valid; ch1 sends 3 beats with in_lock=1,1,0, ptr=1:
  - out_sel is 1,1,1,2,0.
  - ch0 and ch2 see in_ready=0 during the lock, including one cycle where ch1 drops valid mid-burst.
- Non-power-of-two N=3, all valid:
  - out_sel is 0,1,2,0,1.
  - out_sel never equals 3.
- Async reset asserted between edges while out_valid=1 and locked=1:
  - out_valid falls before the next edge.
  - After release with all channels valid, the first grant goes to ch0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating multiplexer with valid/ready channels, a
// registered single-entry output stage and an optional per-channel grant lock.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_lock,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  lock_ch;
    logic             locked;
    logic [SELW-1:0]  grant;
    logic             found;
    logic             space;
    logic             xfer;
    logic [SELW:0]    cand;
    logic [WIDTH-1:0] ch_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Wraps at N, not at 2**SELW, so non-power-of-two N never selects a ghost channel.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] x);
        return (x == SELW'(N - 1)) ? '0 : x + SELW'(1);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant    = '0;
        found    = 1'b0;
        cand     = '0;
        in_ready = '0;
        if (locked) begin
            grant = lock_ch;
            found = in_valid[lock_ch];
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr} + (SELW+1)'(k);
                if (cand >= (SELW+1)'(N))
                    cand = cand - (SELW+1)'(N);
                if (!found && in_valid[cand[SELW-1:0]]) begin
                    found = 1'b1;
                    grant = cand[SELW-1:0];
                end
            end
        end
        space = !out_valid || out_ready;
        xfer  = found && space;
        if (xfer && !rst)
            in_ready[grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant];
                out_sel   <= grant;
                if (locked) begin
                    if (!in_lock[grant]) begin
                        locked <= 1'b0;
                        ptr    <= wrap_inc(lock_ch);
                    end
                end else if (in_lock[grant]) begin
                    locked  <= 1'b1;
                    lock_ch <= grant;
                end else begin
                    ptr <= wrap_inc(grant);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
